mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 37 +++
 rtl/mem_responder.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator (master) and the
// memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding 64-bit word memory responder with a fixed access latency.
// Misaligned or out-of-range requests complete with resp_err and leave memory untouched.
module mem_responder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output logic             busy
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [MEM_WORDS];

  logic [IdxW-1:0] mem_idx;
  logic            addr_bad;
  logic            accept;
  logic            access;
  logic            mem_we;

  assign mem_idx  = addr_q[IdxW+2:3];
  assign addr_bad = (addr_q[2:0] != 3'b000) || (addr_q[63:IdxW+3] != '0);
  assign accept   = ready_q && bus.req_valid;
  assign access   = (state_q == StWait) && (cnt_q == 4'd0);
  // A store caught by reset at its access edge is abandoned, not committed.
  assign mem_we   = access && write_q && !addr_bad && reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = 4'(LATENCY);
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
          err_d   = addr_bad;
          rdata_d = (!addr_bad && !write_q) ? mem_q[mem_idx] : 64'd0;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so that ready drops for the handshake cycle and during reset.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Backing store is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state_q != StIdle);

endmodule
